// File: rtl/apb2axi_tag_directory.sv
// Tag directory for the APB->AXI gateway: holds outstanding descriptors indexed by tag.
// Latency: alloc/pop/status outputs are combinational from registered state; updates land on the next pclk edge.
// Backpressure: alloc_ready drops when every slot is live; each pop channel holds its oldest entry until ready.
package apb2axi_tag_directory_pkg;

  localparam int DIR_ENTRIES = 8;

  typedef enum logic [1:0] {
    ST_EMPTY     = 2'd0,
    ST_ALLOCATED = 2'd1,
    ST_PENDING   = 2'd2,
    ST_COMPLETE  = 2'd3
  } entry_state_e;

  typedef enum logic [1:0] {
    DIR_ST_NONE  = 2'd0,
    DIR_ST_DONE  = 2'd1,
    DIR_ST_ERROR = 2'd2
  } dir_state_e;

  // Tag field is sized for the largest supported directory (64 entries)
  typedef struct packed {
    logic [31:0] addr;
    logic        is_write;
    logic [5:0]  tag;
    dir_state_e  state;
    logic [1:0]  resp;
    logic [7:0]  num_beats;
  } directory_entry_t;

endpackage

module apb2axi_tag_directory
  import apb2axi_tag_directory_pkg::*;
#(
  parameter int DEPTH_P    = DIR_ENTRIES,
  parameter int TAG_W_P    = $clog2(DEPTH_P),
  parameter int TIMEOUT_P  = 4096,
  parameter int TO_CNT_W_P = 16
) (
  input  logic                 pclk,
  input  logic                 presetn,
  input  logic                 alloc_valid,
  input  directory_entry_t     alloc_entry,
  output logic                 alloc_ready,
  output logic [TAG_W_P-1:0]   alloc_tag,
  output logic                 wr_pop_valid,
  output directory_entry_t     wr_pop_entry,
  output logic [TAG_W_P-1:0]   wr_pop_tag,
  input  logic                 wr_pop_ready,
  output logic                 rd_pop_valid,
  output directory_entry_t     rd_pop_entry,
  output logic [TAG_W_P-1:0]   rd_pop_tag,
  input  logic                 rd_pop_ready,
  input  logic                 cpl_valid,
  input  logic [TAG_W_P-1:0]   cpl_tag,
  input  logic                 cpl_error,
  input  logic [1:0]           cpl_resp,
  input  logic [7:0]           cpl_num_beats,
  output logic                 cpl_ready,
  input  logic                 consumed_valid,
  input  logic [TAG_W_P-1:0]   consumed_tag,
  input  logic [TAG_W_P-1:0]   status_tag_sel,
  output directory_entry_t     status_dir_entry,
  output entry_state_e         status_dir_state,
  output logic [TAG_W_P:0]     occupancy,
  output logic                 timeout_valid,
  output logic [TAG_W_P-1:0]   timeout_tag,
  output logic [2:0]           err_sticky,
  input  logic                 err_clear
);

  localparam int OCC_W = TAG_W_P + 1;
  localparam logic [TO_CNT_W_P-1:0] TO_LAST = TO_CNT_W_P'(TIMEOUT_P - 1);

  entry_state_e            st_q     [DEPTH_P];
  directory_entry_t        ent_q    [DEPTH_P];
  logic [TO_CNT_W_P-1:0]   to_cnt_q [DEPTH_P];
  // older_q[i][k] = 1 means entry i was allocated before entry k
  logic [DEPTH_P-1:0]      older_q  [DEPTH_P];
  logic [DEPTH_P-1:0]      older_d  [DEPTH_P];

  logic [DEPTH_P-1:0] wr_cand, rd_cand, wr_head, rd_head;
  logic [DEPTH_P-1:0] pop_hit, cpl_hit, cons_hit, expire;
  logic               alloc_fire, wr_pop_fire, rd_pop_fire;
  logic               cpl_ok, cons_ok;
  logic [TAG_W_P-1:0] to_tag_d;
  directory_entry_t   alloc_ent;

  // Lowest EMPTY slot is the next allocation target
  always_comb begin
    alloc_ready = 1'b0;
    alloc_tag   = '0;
    for (int i = DEPTH_P - 1; i >= 0; i--) begin
      if (st_q[i] == ST_EMPTY) begin
        alloc_ready = 1'b1;
        alloc_tag   = TAG_W_P'(i);
      end
    end
  end

  // Incoming descriptor stamped with the tag it is about to occupy
  always_comb begin
    alloc_ent     = alloc_entry;
    alloc_ent.tag = 6'(alloc_tag);
  end

  // Per-direction head: an ALLOCATED entry with no older ALLOCATED entry of the same direction
  always_comb begin
    for (int i = 0; i < DEPTH_P; i++) begin
      wr_cand[i] = (st_q[i] == ST_ALLOCATED) &&  ent_q[i].is_write;
      rd_cand[i] = (st_q[i] == ST_ALLOCATED) && !ent_q[i].is_write;
    end
    for (int i = 0; i < DEPTH_P; i++) begin
      wr_head[i] = wr_cand[i];
      rd_head[i] = rd_cand[i];
      for (int j = 0; j < DEPTH_P; j++) begin
        if (wr_cand[j] && older_q[j][i]) wr_head[i] = 1'b0;
        if (rd_cand[j] && older_q[j][i]) rd_head[i] = 1'b0;
      end
    end
    wr_pop_tag = '0;
    rd_pop_tag = '0;
    for (int i = 0; i < DEPTH_P; i++) begin
      if (wr_head[i]) wr_pop_tag = TAG_W_P'(i);
      if (rd_head[i]) rd_pop_tag = TAG_W_P'(i);
    end
  end

  assign wr_pop_valid     = |wr_cand;
  assign rd_pop_valid     = |rd_cand;
  assign wr_pop_entry     = ent_q[wr_pop_tag];
  assign rd_pop_entry     = ent_q[rd_pop_tag];
  assign status_dir_entry = ent_q[status_tag_sel];
  assign status_dir_state = st_q[status_tag_sel];

  assign alloc_fire  = alloc_valid  && alloc_ready;
  assign wr_pop_fire = wr_pop_valid && wr_pop_ready;
  assign rd_pop_fire = rd_pop_valid && rd_pop_ready;

  // Decode this cycle's events per entry; a completion on an expiring tag suppresses the timeout
  always_comb begin
    cpl_ok   = cpl_valid && (st_q[cpl_tag] == ST_PENDING);
    cons_ok  = consumed_valid && (st_q[consumed_tag] == ST_COMPLETE);
    to_tag_d = '0;
    for (int i = 0; i < DEPTH_P; i++) begin
      pop_hit[i]  = (wr_pop_fire && (wr_pop_tag == TAG_W_P'(i))) ||
                    (rd_pop_fire && (rd_pop_tag == TAG_W_P'(i)));
      cpl_hit[i]  = cpl_ok && (cpl_tag == TAG_W_P'(i));
      cons_hit[i] = cons_ok && (consumed_tag == TAG_W_P'(i));
      expire[i]   = (TIMEOUT_P != 0) && (st_q[i] == ST_PENDING) &&
                    (to_cnt_q[i] == TO_LAST) && !cpl_hit[i];
    end
    for (int i = DEPTH_P - 1; i >= 0; i--) begin
      if (expire[i]) to_tag_d = TAG_W_P'(i);
    end
  end

  // Age matrix update: new entry becomes youngest, a consumed entry leaves the ordering
  always_comb begin
    older_d = older_q;
    if (alloc_fire) begin
      for (int j = 0; j < DEPTH_P; j++) older_d[j][alloc_tag] = (st_q[j] != ST_EMPTY);
      older_d[alloc_tag] = '0;
    end
    if (cons_ok) begin
      older_d[consumed_tag] = '0;
      for (int j = 0; j < DEPTH_P; j++) older_d[j][consumed_tag] = 1'b0;
    end
  end

  // Age matrix register
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < DEPTH_P; i++) older_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH_P; i++) older_q[i] <= older_d[i];
    end
  end

  // Entry lifecycle: alloc -> pop -> completion or timeout -> consume
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < DEPTH_P; i++) begin
        st_q[i]     <= ST_EMPTY;
        ent_q[i]    <= '0;
        to_cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH_P; i++) begin
        if (alloc_fire && (alloc_tag == TAG_W_P'(i))) begin
          st_q[i]  <= ST_ALLOCATED;
          ent_q[i] <= alloc_ent;
        end
        if (pop_hit[i]) begin
          st_q[i]     <= ST_PENDING;
          to_cnt_q[i] <= '0;
        end else if ((TIMEOUT_P != 0) && (st_q[i] == ST_PENDING)) begin
          to_cnt_q[i] <= to_cnt_q[i] + 1'b1;
        end
        if (cpl_hit[i]) begin
          st_q[i]           <= ST_COMPLETE;
          ent_q[i].resp      <= cpl_resp;
          ent_q[i].num_beats <= cpl_num_beats;
          ent_q[i].state     <= cpl_error ? DIR_ST_ERROR : DIR_ST_DONE;
        end else if (expire[i]) begin
          st_q[i]           <= ST_COMPLETE;
          ent_q[i].resp      <= 2'b10;
          ent_q[i].num_beats <= '0;
          ent_q[i].state     <= DIR_ST_ERROR;
        end
        if (cons_hit[i]) begin
          st_q[i]  <= ST_EMPTY;
          ent_q[i] <= '0;
        end
      end
    end
  end

  // Occupancy, timeout pulse, sticky errors and completion-ready
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      occupancy     <= '0;
      timeout_valid <= 1'b0;
      timeout_tag   <= '0;
      err_sticky    <= '0;
      cpl_ready     <= 1'b0;
    end else begin
      cpl_ready     <= 1'b1;
      occupancy     <= occupancy + OCC_W'(alloc_fire) - OCC_W'(cons_ok);
      timeout_valid <= |expire;
      timeout_tag   <= to_tag_d;
      if (err_clear) begin
        err_sticky <= '0;
      end else begin
        err_sticky <= err_sticky | {|expire, consumed_valid && !cons_ok, cpl_valid && !cpl_ok};
      end
    end
  end

endmodule

// File: tb/tb_apb2axi_tag_directory.sv
// Bench for apb2axi_tag_directory: directed scenarios plus random traffic against a queue-based model.
// Inputs are driven at the falling edge; outputs are compared 1 time unit later.
// Every mismatch prints a FAIL line; one summary line ends the run.
module tb_apb2axi_tag_directory;
  import apb2axi_tag_directory_pkg::*;

  localparam int DEPTH = 4;
  localparam int TW    = 2;
  localparam int TO    = 16;

  logic             pclk, presetn;
  logic             alloc_valid, alloc_ready;
  directory_entry_t alloc_entry;
  logic [TW-1:0]    alloc_tag;
  logic             wr_pop_valid, wr_pop_ready, rd_pop_valid, rd_pop_ready;
  directory_entry_t wr_pop_entry, rd_pop_entry, status_dir_entry;
  logic [TW-1:0]    wr_pop_tag, rd_pop_tag;
  logic             cpl_valid, cpl_error, cpl_ready;
  logic [TW-1:0]    cpl_tag, consumed_tag, status_tag_sel, timeout_tag;
  logic [1:0]       cpl_resp;
  logic [7:0]       cpl_num_beats;
  logic             consumed_valid, timeout_valid, err_clear;
  entry_state_e     status_dir_state;
  logic [TW:0]      occupancy;
  logic [2:0]       err_sticky;

  apb2axi_tag_directory #(.DEPTH_P(DEPTH), .TIMEOUT_P(TO), .TO_CNT_W_P(16)) dut (
    .pclk(pclk), .presetn(presetn),
    .alloc_valid(alloc_valid), .alloc_entry(alloc_entry), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .wr_pop_valid(wr_pop_valid), .wr_pop_entry(wr_pop_entry), .wr_pop_tag(wr_pop_tag), .wr_pop_ready(wr_pop_ready),
    .rd_pop_valid(rd_pop_valid), .rd_pop_entry(rd_pop_entry), .rd_pop_tag(rd_pop_tag), .rd_pop_ready(rd_pop_ready),
    .cpl_valid(cpl_valid), .cpl_tag(cpl_tag), .cpl_error(cpl_error), .cpl_resp(cpl_resp),
    .cpl_num_beats(cpl_num_beats), .cpl_ready(cpl_ready),
    .consumed_valid(consumed_valid), .consumed_tag(consumed_tag),
    .status_tag_sel(status_tag_sel), .status_dir_entry(status_dir_entry), .status_dir_state(status_dir_state),
    .occupancy(occupancy), .timeout_valid(timeout_valid), .timeout_tag(timeout_tag),
    .err_sticky(err_sticky), .err_clear(err_clear)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: per-tag state, cycles since pop, and allocation-order queues per direction
  entry_state_e     m_st  [DEPTH];
  directory_entry_t m_ent [DEPTH];
  int               m_age [DEPTH];
  int               wq[$], rq[$];
  logic [2:0]       m_err;
  logic             m_tv, m_cpl_rdy, seen_tv;
  int               m_tt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_st[i] = ST_EMPTY; m_ent[i] = '0; m_age[i] = 0;
    end
    wq.delete(); rq.delete();
    m_err = '0; m_tv = 1'b0; m_tt = 0; m_cpl_rdy = 1'b0;
  endtask

  task automatic check_outputs();
    int lo, occ;
    lo = -1; occ = 0;
    for (int i = DEPTH - 1; i >= 0; i--) if (m_st[i] == ST_EMPTY) lo = i;
    for (int i = 0; i < DEPTH; i++) if (m_st[i] != ST_EMPTY) occ++;
    chk("alloc_ready", 64'(alloc_ready), 64'(lo >= 0));
    if (lo >= 0) chk("alloc_tag", 64'(alloc_tag), 64'(lo));
    chk("wr_pop_valid", 64'(wr_pop_valid), 64'(wq.size() > 0));
    if (wq.size() > 0) begin
      chk("wr_pop_tag", 64'(wr_pop_tag), 64'(wq[0]));
      chk("wr_pop_entry", 64'(wr_pop_entry), 64'(m_ent[wq[0]]));
    end
    chk("rd_pop_valid", 64'(rd_pop_valid), 64'(rq.size() > 0));
    if (rq.size() > 0) begin
      chk("rd_pop_tag", 64'(rd_pop_tag), 64'(rq[0]));
      chk("rd_pop_entry", 64'(rd_pop_entry), 64'(m_ent[rq[0]]));
    end
    chk("occupancy", 64'(occupancy), 64'(occ));
    chk("err_sticky", 64'(err_sticky), 64'(m_err));
    chk("timeout_valid", 64'(timeout_valid), 64'(m_tv));
    if (m_tv) chk("timeout_tag", 64'(timeout_tag), 64'(m_tt));
    chk("cpl_ready", 64'(cpl_ready), 64'(m_cpl_rdy));
    chk("status_state", 64'(status_dir_state), 64'(m_st[status_tag_sel]));
    chk("status_entry", 64'(status_dir_entry), 64'(m_ent[status_tag_sel]));
    seen_tv = timeout_valid;
  endtask

  // Advance the model by one clock using the inputs currently applied
  task automatic model_step();
    entry_state_e ps [DEPTH];
    int wt, rt, at, first;
    logic [2:0] ev;
    for (int i = 0; i < DEPTH; i++) ps[i] = m_st[i];
    wt = -1; rt = -1; at = -1; first = -1; ev = '0;
    if (wr_pop_ready && wq.size() > 0) wt = wq.pop_front();
    if (rd_pop_ready && rq.size() > 0) rt = rq.pop_front();
    if (alloc_valid) for (int i = DEPTH - 1; i >= 0; i--) if (ps[i] == ST_EMPTY) at = i;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == at) begin
        m_st[i] = ST_ALLOCATED; m_ent[i] = alloc_entry; m_ent[i].tag = 6'(i);
        if (alloc_entry.is_write) wq.push_back(i); else rq.push_back(i);
      end else if (i == wt || i == rt) begin
        m_st[i] = ST_PENDING; m_age[i] = 0;
      end else if (ps[i] == ST_PENDING) begin
        if (cpl_valid && int'(cpl_tag) == i) begin
          m_st[i] = ST_COMPLETE; m_ent[i].resp = cpl_resp; m_ent[i].num_beats = cpl_num_beats;
          m_ent[i].state = cpl_error ? DIR_ST_ERROR : DIR_ST_DONE;
        end else begin
          m_age[i]++;
          if (m_age[i] == TO) begin
            m_st[i] = ST_COMPLETE; m_ent[i].resp = 2'b10; m_ent[i].num_beats = 8'd0;
            m_ent[i].state = DIR_ST_ERROR;
            if (first < 0) first = i;
          end
        end
      end else if (ps[i] == ST_COMPLETE && consumed_valid && int'(consumed_tag) == i) begin
        m_st[i] = ST_EMPTY; m_ent[i] = '0;
      end
    end
    if (cpl_valid && ps[cpl_tag] != ST_PENDING) ev[0] = 1'b1;
    if (consumed_valid && ps[consumed_tag] != ST_COMPLETE) ev[1] = 1'b1;
    ev[2] = (first >= 0);
    m_err = err_clear ? 3'b000 : (m_err | ev);
    m_tv = (first >= 0); m_tt = first; m_cpl_rdy = 1'b1;
  endtask

  task automatic cycle();
    #1;
    check_outputs();
    model_step();
    @(posedge pclk);
    @(negedge pclk);
  endtask

  task automatic idle();
    alloc_valid = 0; alloc_entry = '0; wr_pop_ready = 0; rd_pop_ready = 0;
    cpl_valid = 0; cpl_tag = '0; cpl_error = 0; cpl_resp = '0; cpl_num_beats = '0;
    consumed_valid = 0; consumed_tag = '0; err_clear = 0;
  endtask

  task automatic set_alloc(input bit w);
    alloc_valid = 1; alloc_entry.addr = $urandom; alloc_entry.is_write = w;
    alloc_entry.tag = 6'($urandom);
  endtask

  task automatic do_alloc(input bit w);
    idle(); set_alloc(w); cycle();
  endtask

  task automatic do_pop(input bit w, input bit r);
    idle(); wr_pop_ready = w; rd_pop_ready = r; cycle();
  endtask

  task automatic do_cpl(input int t, input bit e, input int resp, input int beats);
    idle(); cpl_valid = 1; cpl_tag = TW'(t); cpl_error = e;
    cpl_resp = 2'(resp); cpl_num_beats = 8'(beats); cycle();
  endtask

  task automatic do_cons(input int t);
    idle(); consumed_valid = 1; consumed_tag = TW'(t); cycle();
  endtask

  // Reset asserted between clock edges; outputs must clear without a clock
  task automatic do_reset();
    idle();
    #2 presetn = 1'b0;
    #1;
    chk("rst_wr_pop_valid", 64'(wr_pop_valid), 64'(0));
    chk("rst_rd_pop_valid", 64'(rd_pop_valid), 64'(0));
    chk("rst_occupancy", 64'(occupancy), 64'(0));
    chk("rst_alloc_tag", 64'(alloc_tag), 64'(0));
    chk("rst_alloc_ready", 64'(alloc_ready), 64'(1));
    chk("rst_cpl_ready", 64'(cpl_ready), 64'(0));
    chk("rst_err_sticky", 64'(err_sticky), 64'(0));
    model_reset();
    @(negedge pclk);
    @(negedge pclk);
    presetn = 1'b1;
  endtask

  function automatic logic [TW-1:0] pick(input entry_state_e s);
    int c[$];
    for (int i = 0; i < DEPTH; i++) if (m_st[i] == s) c.push_back(i);
    if (c.size() > 0 && $urandom_range(0, 3) != 0) return TW'(c[$urandom_range(0, c.size() - 1)]);
    return TW'($urandom_range(0, DEPTH - 1));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    presetn = 1'b1; status_tag_sel = '0; seen_tv = 1'b0;
    idle(); model_reset();
    @(negedge pclk);
    do_reset();

    // Fill W,R,W,R; both pop channels present distinct oldest tags
    do_alloc(1); do_alloc(0); do_alloc(1); do_alloc(0);
    idle(); #1;
    chk("full_alloc_ready", 64'(alloc_ready), 64'(0));
    chk("full_occupancy", 64'(occupancy), 64'(4));
    chk("full_wr_pop_tag", 64'(wr_pop_tag), 64'(0));
    chk("full_rd_pop_tag", 64'(rd_pop_tag), 64'(1));
    do_pop(1, 1);
    do_cpl(1, 0, 0, 4);
    do_cons(1);
    idle(); #1;
    chk("reuse_alloc_tag", 64'(alloc_tag), 64'(1));
    do_alloc(0);
    idle(); #1;
    chk("age_rd_first", 64'(rd_pop_tag), 64'(3));
    do_pop(0, 1);
    idle(); #1;
    chk("age_rd_second", 64'(rd_pop_tag), 64'(1));
    do_reset();

    // Completion with error on one tag while an older one stays pending
    do_alloc(1); do_alloc(1);
    do_pop(1, 0); do_pop(1, 0);
    do_cpl(1, 1, 2, 3);
    idle(); status_tag_sel = 1; #1;
    chk("cpl_err_state", 64'(status_dir_state), 64'(ST_COMPLETE));
    chk("cpl_err_dirst", 64'(status_dir_entry.state), 64'(DIR_ST_ERROR));
    status_tag_sel = 0; #1;
    chk("cpl_other_pending", 64'(status_dir_state), 64'(ST_PENDING));
    do_cpl(0, 0, 0, 8);
    idle(); #1;
    chk("cpl_ok_dirst", 64'(status_dir_entry.state), 64'(DIR_ST_DONE));
    chk("cpl_ok_beats", 64'(status_dir_entry.num_beats), 64'(8));
    do_reset();

    // Timeout fires 16 cycles after pop; a late completion is flagged
    status_tag_sel = 0;
    do_alloc(1); do_pop(1, 0);
    k = 0;
    while (k < 40) begin
      idle(); cycle();
      if (seen_tv) break;
      k++;
    end
    chk("to_latency", 64'(k), 64'(TO));
    idle(); #1;
    chk("to_err_sticky", 64'(err_sticky), 64'(3'b100));
    chk("to_resp", 64'(status_dir_entry.resp), 64'(2'b10));
    do_cpl(0, 0, 0, 1);
    idle(); #1;
    chk("late_cpl_err", 64'(err_sticky), 64'(3'b101));
    do_reset();

    // Bad consume and bad completion are ignored but recorded; clear wipes them
    do_alloc(1);
    do_cons(0);
    do_cpl(2, 0, 1, 1);
    idle(); status_tag_sel = 0; #1;
    chk("bad_err_sticky", 64'(err_sticky), 64'(3'b011));
    chk("bad_state_kept", 64'(status_dir_state), 64'(ST_ALLOCATED));
    idle(); err_clear = 1; cycle();
    idle(); #1;
    chk("err_cleared", 64'(err_sticky), 64'(0));

    // Reset with three PENDING entries and one ALLOCATED read
    do_reset();
    do_alloc(1); do_alloc(0); do_alloc(1); do_alloc(0);
    do_pop(1, 1); do_pop(1, 0);
    idle(); #1;
    chk("pre_rst_rd_valid", 64'(rd_pop_valid), 64'(1));
    do_reset();

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      idle();
      if ($urandom_range(0, 1) == 1) set_alloc(1'($urandom_range(0, 1)));
      wr_pop_ready = ($urandom_range(0, 2) == 0);
      rd_pop_ready = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) < 4) begin
        cpl_valid = 1; cpl_tag = pick(ST_PENDING); cpl_error = 1'($urandom_range(0, 1));
        cpl_resp = 2'($urandom_range(0, 3)); cpl_num_beats = 8'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 9) < 4) begin
        consumed_valid = 1; consumed_tag = pick(ST_COMPLETE);
      end
      err_clear = ($urandom_range(0, 19) == 0);
      status_tag_sel = TW'($urandom_range(0, DEPTH - 1));
      cycle();
    end

    idle(); cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/apb2axi_tag_directory.md
Name: apb2axi_tag_directory

Overview:
Next-generation APB→AXI gateway tag directory. Holds outstanding transaction descriptors, indexed by TAG. Improvements over the previous directory:
- allocates any free slot, not only a round-robin slot;
- separate read and write pop channels, each strictly oldest-first;
- per-entry pending timeout;
- occupancy count and sticky protocol-error reporting.

The block sits between the APB register front-end (alloc, status, consume) and the AXI transaction managers (pop, completion).

Parameters:
DEPTH_P, DIR_ENTRIES, number of directory entries (power of 2, 2..64)
TAG_W_P, $clog2(DEPTH_P), TAG width
TIMEOUT_P, 4096, cycles an entry may stay PENDING before forced error completion; 0 disables timeout
TO_CNT_W_P, 16, width of per-entry timeout counter (must hold TIMEOUT_P)

Ports:
pclk  in  1  clock
presetn  in  1  reset. One clock; reset is asynchronous and active-low.
alloc_valid  in  1  new descriptor offered
alloc_entry  in  directory_entry_t  descriptor; is_write selects pop channel
alloc_ready  out  1  a free entry exists
alloc_tag  out  TAG_W_P  tag that the current alloc handshake takes (combinational)
wr_pop_valid / rd_pop_valid  out  1  an ALLOCATED write / read entry is available
wr_pop_entry / rd_pop_entry  out  directory_entry_t  oldest entry of that direction
wr_pop_tag / rd_pop_tag  out  TAG_W_P  its tag
wr_pop_ready / rd_pop_ready  in  1  manager accepts
cpl_valid  in  1  completion
cpl_tag  in  TAG_W_P  completed tag
cpl_error  in  1  transaction error
cpl_resp  in  2  AXI response
cpl_num_beats  in  8  beats transferred
cpl_ready  out  1  tied 1 after reset
consumed_valid  in  1  software is done with a tag
consumed_tag  in  TAG_W_P  tag to free
status_tag_sel  in  TAG_W_P  status index
status_dir_entry  out  directory_entry_t  entry[status_tag_sel] (combinational)
status_dir_state  out  entry_state_e  state[status_tag_sel] (combinational)
occupancy  out  TAG_W_P+1  registered count of non-EMPTY entries
timeout_valid  out  1  one-cycle pulse when an entry times out
timeout_tag  out  TAG_W_P  lowest-index timed-out tag that cycle
err_sticky  out  3  bit0 bad completion, bit1 bad consume, bit2 timeout occurred
err_clear  in  1  clears err_sticky

Behaviour:
- **Reset (async, presetn=0):**
  - all states ST_EMPTY and entries '0;
  - age matrix, timeout counters, occupancy, err_sticky, timeout_valid, timeout_tag reset to 0;
  - cpl_ready=0 during reset, 1 afterwards;
  - a reset mid-operation drops every entry with no completion emitted.
- **Allocation:**
  - alloc_ready = OR of (state==ST_EMPTY).
  - alloc_tag = lowest EMPTY index, computed from registered state.
  - On handshake: entry ← alloc_entry with .tag=alloc_tag; state ← ST_ALLOCATED; the entry becomes youngest in the age matrix. The age update sets older[j][tag]=1 for all non-EMPTY j and clears row tag.
  - A slot freed by consume this cycle is allocatable next cycle, not the same cycle.
- **Pop:**
  - Per direction, valid = some ALLOCATED entry with matching is_write.
  - Selected tag is the one with no older ALLOCATED same-direction entry.
  - On valid&&ready: state ← ST_PENDING and the timeout counter is cleared.
  - Both channels may pop in the same cycle; they always select distinct tags.
  - An entry allocated in cycle N is poppable in N+1.
- **Completion:**
  - Accepted only if state[cpl_tag]==ST_PENDING: state ← ST_COMPLETE; resp and num_beats captured; .state ← DIR_ST_ERROR if cpl_error, else DIR_ST_DONE.
  - Completion on any other state is ignored and sets err_sticky[0].
- **Timeout (TIMEOUT_P>0):**
  - Each PENDING entry's counter increments every cycle.
  - On reaching TIMEOUT_P: state ← ST_COMPLETE, .state ← DIR_ST_ERROR, resp ← 2'b10, num_beats ← 0.
  - Also: timeout_valid=1 for one cycle with the lowest such tag; err_sticky[2] set.
  - If several entries time out in one cycle, all transition.
  - A completion arriving the same cycle as the timeout on the same tag wins (normal completion, no timeout).
  - A later completion on a timed-out tag counts as a bad completion.
- **Consume:**
  - If state[consumed_tag]==ST_COMPLETE: state ← ST_EMPTY, entry ← '0, age row/column cleared.
  - Otherwise ignored and sets err_sticky[1].
- **Occupancy:** updated each cycle as previous + allocs − consumes. Never exceeds DEPTH_P.
- **Sticky errors:** err_clear has priority under simultaneous set, i.e. the clear wins that cycle and the new event is lost.
- **Same-cycle events:** pop, completion and consume on different tags in the same cycle all take effect.

Test Plan:
- DEPTH_P=4: allocate 4 (W,R,W,R) → tags 0,1,2,3; alloc_ready=0; occupancy=4. wr_pop_tag=0 and rd_pop_tag=1 simultaneously.
- Consume tag 1 after completion with 4 entries live → next alloc_tag=1. The new entry pops after the older same-direction entry 3, not before.
- Allocate W tags 0,1; pop both; complete 1 with cpl_error=1, resp=2 → entry 1 COMPLETE/DIR_ST_ERROR, tag 0 still PENDING. Complete 0 with resp=0, num_beats=8 → DONE, beats=8.
- TIMEOUT_P=16: pop tag 0, no completion → at cycle 16 after pop, timeout_valid pulses with tag 0; resp=2'b10; err_sticky=3'b100. A late cpl on tag 0 sets err_sticky[0].
- Consume of an ALLOCATED tag, and cpl of an EMPTY tag → both ignored; state unchanged; err_sticky=3'b011. err_clear → 0.
- presetn dropped with 3 PENDING entries → all ST_EMPTY, occupancy=0, pop valids 0 asynchronously; post-reset alloc_tag=0.
